// File: rtl/iq_pkg.sv
// Shared definitions for the decode-to-dispatch instruction queue: packed entry
// field layout, default entry width and the issue-type codes used by the dispatcher.
package iq_pkg;

  localparam int PC_LSB     = 0;
  localparam int NPC_LSB    = 32;
  localparam int IR_LSB     = 64;
  localparam int IMM_LSB    = 96;
  localparam int CTRL_LSB   = 128;
  localparam int RK_LSB     = 160;
  localparam int RJ_LSB     = 165;
  localparam int RD_LSB     = 170;
  localparam int EXCP_LSB   = 175;
  localparam int PRE_LSB    = 191;
  localparam int IQ_ENTRY_W = 255;

  // Issue-type encoding carried in the control field, shared with the dispatcher.
  typedef enum logic [3:0] {
    ISS_ALU   = 4'd0,
    ISS_MUL   = 4'd1,
    ISS_DIV   = 4'd2,
    ISS_BR    = 4'd3,
    ISS_LD    = 4'd4,
    ISS_ST    = 4'd5,
    ISS_CSR   = 4'd6,
    ISS_TLB   = 4'd7,
    ISS_CACHE = 4'd8,
    ISS_BAR   = 4'd9,
    ISS_EXCP  = 4'd10,
    ISS_MMU   = 4'd11
  } issue_type_e;

  function automatic logic [31:0] entry_pc(input logic [IQ_ENTRY_W-1:0] e);
    return e[PC_LSB +: 32];
  endfunction

endpackage

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: two write ports, two asynchronous read
// ports, data is not reset (validity is tracked by the pointers in the top).
module iq_storage #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 255,
  parameter int PW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [PW-1:0]      wa0,
  input  logic [ENTRY_W-1:0] wd0,
  input  logic               we1,
  input  logic [PW-1:0]      wa1,
  input  logic [ENTRY_W-1:0] wd1,
  input  logic [PW-1:0]      ra0,
  output logic [ENTRY_W-1:0] rd0,
  input  logic [PW-1:0]      ra1,
  output logic [ENTRY_W-1:0] rd1
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // The two write addresses are always distinct, so port order does not matter.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/dual_inst_queue.sv
// Dual-issue instruction queue between decode and dispatch. Optional performance
// counters are built only when IQ_PERF_CNT_EN is defined.
module dual_inst_queue
  import iq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = IQ_ENTRY_W,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid0,
  input  logic               in_valid1,
  input  logic [ENTRY_W-1:0] in_entry0,
  input  logic [ENTRY_W-1:0] in_entry1,
  output logic               in_ready,
  output logic               out_valid_old,
  output logic               out_valid_young,
  output logic [ENTRY_W-1:0] out_entry_old,
  output logic [ENTRY_W-1:0] out_entry_young,
  input  logic               issue_old,
  input  logic               issue_young,
  output logic [CNT_W-1:0]   perf_empty_cyc,
  output logic [CNT_W-1:0]   perf_dual_cnt,
  output logic [CNT_W-1:0]   perf_single_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] READY_MAX = (PW+1)'(DEPTH - 2);

  logic [PW:0]        head_reg, tail_reg, count, n_push, n_pop;
  logic               push_en, we0, we1, pop_old, pop_young;
  logic [PW-1:0]      wa0, wa1, ra0, ra1;
  logic [ENTRY_W-1:0] rd0, rd1;

  assign count           = tail_reg - head_reg;
  assign in_ready        = (count <= READY_MAX);
  assign out_valid_old   = (count != '0);
  assign out_valid_young = (count > (PW+1)'(1));

  // A lone younger instruction is compacted down to the tail slot.
  assign push_en = in_ready & ~flush;
  assign we0     = push_en & in_valid0;
  assign we1     = push_en & in_valid1;
  assign wa0     = tail_reg[PW-1:0];
  assign wa1     = tail_reg[PW-1:0] + PW'(in_valid0);
  assign n_push  = (PW+1)'(we0) + (PW+1)'(we1);

  assign pop_old   = ~stall & ~flush & issue_old & out_valid_old;
  assign pop_young = ~stall & ~flush & issue_old & issue_young & out_valid_young;
  assign n_pop     = (PW+1)'(pop_old) + (PW+1)'(pop_young);

  assign ra0 = head_reg[PW-1:0];
  assign ra1 = head_reg[PW-1:0] + PW'(1);

  iq_storage #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .PW(PW)) u_storage (
    .clk(clk),
    .we0(we0), .wa0(wa0), .wd0(in_entry0),
    .we1(we1), .wa1(wa1), .wd1(in_entry1),
    .ra0(ra0), .rd0(rd0),
    .ra1(ra1), .rd1(rd1)
  );

  assign out_entry_old   = out_valid_old   ? rd0 : '0;
  assign out_entry_young = out_valid_young ? rd1 : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else if (flush) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_reg + n_pop;
      tail_reg <= tail_reg + n_push;
    end
  end

`ifdef IQ_PERF_CNT_EN
  logic [2:0]       perf_inc;
  logic [CNT_W-1:0] perf_reg [3];

  assign perf_inc = {pop_old & ~pop_young, pop_young, (count == '0)};

  // Saturating counters: 0 empty cycles, 1 dual pops, 2 single pops.
  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
        perf_reg[gi] <= '0;
      else if (perf_inc[gi] && !(&perf_reg[gi]))
        perf_reg[gi] <= perf_reg[gi] + CNT_W'(1);
    end
  end

  assign perf_empty_cyc  = perf_reg[0];
  assign perf_dual_cnt   = perf_reg[1];
  assign perf_single_cnt = perf_reg[2];
`else
  assign perf_empty_cyc  = '0;
  assign perf_dual_cnt   = '0;
  assign perf_single_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_inst_queue.sv
// Self-checking bench for dual_inst_queue: a queue-based reference model checked
// every cycle, plus directed literal checks on the program-counter sequence.
module tb_dual_inst_queue;
  localparam int DEPTH = 8;
  localparam int EW    = 255;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 0, stall = 0, in_valid0 = 0, in_valid1 = 0;
  logic          issue_old = 0, issue_young = 0;
  logic [EW-1:0] in_entry0 = '0, in_entry1 = '0;
  logic          in_ready, out_valid_old, out_valid_young;
  logic [EW-1:0] out_entry_old, out_entry_young;
  logic [CW-1:0] perf_empty_cyc, perf_dual_cnt, perf_single_cnt;

  int checks = 0;
  int errors = 0;

  dual_inst_queue #(.DEPTH(DEPTH), .ENTRY_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_entry0(in_entry0), .in_entry1(in_entry1),
    .in_ready(in_ready),
    .out_valid_old(out_valid_old), .out_valid_young(out_valid_young),
    .out_entry_old(out_entry_old), .out_entry_young(out_entry_young),
    .issue_old(issue_old), .issue_young(issue_young),
    .perf_empty_cyc(perf_empty_cyc), .perf_dual_cnt(perf_dual_cnt),
    .perf_single_cnt(perf_single_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [31:0] pc);
    logic [EW-1:0] e;
    e = '0;
    e[31:0]    = pc;
    e[63:32]   = pc + 32'd4;
    e[95:64]   = pc ^ 32'h5a5a_0000;
    e[254:191] = {pc, ~pc};
    return e;
  endfunction

  // Reference model: FIFO of entries and plain counters.
  logic [EW-1:0] mq [$];
  int m_empty = 0, m_dual = 0, m_single = 0;

  always @(posedge clk or negedge rstn) begin
    int sz, npop;
    bit rdy;
    if (!rstn) begin
      mq.delete();
      m_empty = 0; m_dual = 0; m_single = 0;
    end else begin
      sz = mq.size();
      rdy = (DEPTH - sz) >= 2;
      npop = 0;
      if (flush) begin
        mq.delete();
      end else begin
        if (!stall && issue_old && sz >= 1) begin
          void'(mq.pop_front()); npop = 1;
          if (issue_young && sz >= 2) begin void'(mq.pop_front()); npop = 2; end
        end
        if (rdy) begin
          if (in_valid0) mq.push_back(in_entry0);
          if (in_valid1) mq.push_back(in_entry1);
        end
      end
      if (sz == 0) m_empty++;
      if (npop == 2) m_dual++;
      if (npop == 1) m_single++;
    end
  end

  always @(negedge clk) begin
    int sz;
    if (rstn) begin
      sz = mq.size();
      chk("in_ready", in_ready, (DEPTH - sz) >= 2);
      chk("valid_old", out_valid_old, sz >= 1);
      chk("valid_young", out_valid_young, sz >= 2);
      chk("entry_old", out_entry_old, (sz >= 1) ? mq[0] : '0);
      chk("entry_young", out_entry_young, (sz >= 2) ? mq[1] : '0);
`ifdef IQ_PERF_CNT_EN
      chk("perf_empty", perf_empty_cyc, m_empty);
      chk("perf_dual", perf_dual_cnt, m_dual);
      chk("perf_single", perf_single_cnt, m_single);
`else
      chk("perf_empty", perf_empty_cyc, 0);
      chk("perf_dual", perf_dual_cnt, 0);
      chk("perf_single", perf_single_cnt, 0);
`endif
    end
  end

  // Apply one cycle of inputs, then return just after the edge.
  task automatic cyc(input bit v0, input bit v1, input logic [31:0] pc0, input logic [31:0] pc1,
                     input bit io, input bit iy, input bit st, input bit fl);
    in_valid0 = v0; in_valid1 = v1;
    in_entry0 = v0 ? mk(pc0) : '0;
    in_entry1 = v1 ? mk(pc1) : '0;
    issue_old = io; issue_young = iy; stall = st; flush = fl;
    @(posedge clk); #1;
    in_valid0 = 0; in_valid1 = 0; issue_old = 0; issue_young = 0; stall = 0; flush = 0;
  endtask

  initial begin
    logic [31:0] pcw;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid_old", out_valid_old, 0);
    chk("rst_valid_young", out_valid_young, 0);
    chk("rst_entry_old", out_entry_old, '0);
    chk("rst_entry_young", out_entry_young, '0);
    chk("rst_perf", {perf_empty_cyc, perf_dual_cnt, perf_single_cnt}, '0);
    @(negedge clk); #2; rstn = 1;
    @(posedge clk); #1;
    $display("txn reset released");

    cyc(1, 1, 32'h1c000000, 32'h1c000004, 0, 0, 0, 0);
    chk("push2_valid", {out_valid_old, out_valid_young}, 2'b11);
    chk("push2_old_pc", out_entry_old[31:0], 32'h1c000000);
    chk("push2_young_pc", out_entry_young[31:0], 32'h1c000004);
    $display("txn push pair pc0=1c000000 pc1=1c000004");

    cyc(1, 1, 32'h1c000008, 32'h1c00000c, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("pop1_old_pc", out_entry_old[31:0], 32'h1c000004);
    $display("txn single pop");
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("pop2_old_pc", out_entry_old[31:0], 32'h1c00000c);
    chk("pop2_young_valid", out_valid_young, 0);
`ifdef IQ_PERF_CNT_EN
    chk("pop2_perf_dual", perf_dual_cnt, 1);
`endif
    $display("txn dual pop");
    cyc(0, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 3; i++)
      cyc(1, 1, 32'h1c000200 + 8 * i, 32'h1c000204 + 8 * i, 0, 0, 0, 0);
    cyc(1, 0, 32'h1c000218, 0, 0, 0, 0, 0);
    chk("full7_in_ready", in_ready, 0);
    $display("txn filled to 7");
    cyc(1, 1, 32'h1c000900, 32'h1c000904, 1, 1, 0, 0);
    chk("full_pop_in_ready", in_ready, 1);
    chk("full_pop_old_pc", out_entry_old[31:0], 32'h1c000208);
    $display("txn pop 2 with ignored push");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("drained", out_valid_old, 0);

    pcw = 32'h1c001000;
    cyc(1, 0, pcw, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, pcw + 4 * (i + 1), 0, 1, 0, 0, 0);
      chk("wrap_old_pc", out_entry_old[31:0], pcw + 4 * (i + 1));
      $display("txn wrap step %0d", i);
    end
    cyc(0, 0, 0, 0, 1, 0, 0, 0);

    cyc(1, 1, 32'h1c002000, 32'h1c002004, 0, 0, 0, 0);
    cyc(1, 1, 32'h1c002008, 32'h1c00200c, 1, 1, 1, 0);
    chk("stall_old_pc", out_entry_old[31:0], 32'h1c002000);
    $display("txn stall with push");
    cyc(1, 1, 32'h1c003000, 32'h1c003004, 1, 1, 0, 1);
    chk("flush_valid_old", out_valid_old, 0);
    chk("flush_entry_old", out_entry_old, '0);
    chk("flush_in_ready", in_ready, 1);
    $display("txn flush");

    cyc(0, 1, 0, 32'h1c000100, 0, 0, 0, 0);
    chk("v1only_old_pc", out_entry_old[31:0], 32'h1c000100);
    chk("v1only_young_valid", out_valid_young, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("young_alone_nopop", {out_valid_old, out_entry_old[31:0]}, {1'b1, 32'h1c000100});
    $display("txn compaction and young-alone issue");

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_inst_queue.md
Name: dual_inst_queue

Overview:
- Decode-to-dispatch instruction buffer; sits directly upstream of the dual-issue dispatcher.
- Accepts 0–2 decoded instructions per cycle in program order.
- Presents the two oldest entries to the dispatcher:
  - old slot feeds the dispatcher's full-function pipe input (suffix 1);
  - young slot feeds the ALU/MUL/DIV pipe input (suffix 0).
- Pops 0, 1 or 2 entries per cycle according to the dispatcher's issue flags.

Parameters:
- DEPTH, 8, number of entries; power of two, >=4
- ENTRY_W, 255, packed entry width {pre[63:0], excp_arg[15:0], rd[4:0], rj[4:0], rk[4:0], control[31:0], imm[31:0], ir[31:0], npc[31:0], pc[31:0]}
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  branch/exception flush; clears queue
- stall  in  1  backend stall; blocks pops
- in_valid0  in  1  older incoming instruction valid
- in_valid1  in  1  younger incoming instruction valid
- in_entry0  in  ENTRY_W  older incoming entry
- in_entry1  in  ENTRY_W  younger incoming entry
- in_ready  out  1  queue has >=2 free entries
- out_valid_old  out  1  head entry valid (to dispatcher valid1)
- out_valid_young  out  1  head+1 entry valid (to dispatcher valid0)
- out_entry_old  out  ENTRY_W  head entry (to dispatcher *1 fields)
- out_entry_young  out  ENTRY_W  head+1 entry (to dispatcher *0 fields)
- issue_old  in  1  dispatcher if1
- issue_young  in  1  dispatcher if0
- perf_empty_cyc  out  CNT_W  cycles with queue empty
- perf_dual_cnt  out  CNT_W  dual-pop events
- perf_single_cnt  out  CNT_W  single-pop events

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rstn). Reset: head=tail=0, count=0, all perf counters 0. Outputs then: in_ready=1, both out_valid 0, both out_entry 0.
- Pointers are log2(DEPTH)+1 bits with a wrap bit; count = tail-head. Wrap-around is modulo DEPTH.
- in_ready = (DEPTH-count)>=2, computed from registered count only; same-cycle pops are not credited.
- Push:
  - accepted when in_ready and not flush;
  - n_push = in_valid0+in_valid1;
  - if only in_valid1 is set, it is written at tail (compaction);
  - otherwise entry0 goes to tail, entry1 to tail+1;
  - tail += n_push.
- Push is independent of stall.
- Latency: a pushed entry is visible at the outputs the next cycle. No bypass.
- Outputs are combinational reads at head and head+1.
  - out_valid_old = count>=1; out_valid_young = count>=2.
  - Each out_entry is forced to 0 when its valid is 0.
- Pop (when not stall and not flush):
  - pop_old = issue_old & out_valid_old;
  - pop_young = issue_young & issue_old & out_valid_young;
  - head += pop_old+pop_young.
- issue_young without issue_old pops nothing (the dispatcher never issues the younger instruction alone).
- Both issue flags 0 (dispatcher RAW-hazard bubble): no pop; outputs hold.
- Simultaneous push and pop: count_next = count + n_push - n_pop. Full at DEPTH-1 with a pop: in_ready stays 0 that cycle.
- Flush has the highest priority:
  - next cycle head=tail=0 and count=0;
  - same-cycle push and pop are discarded;
  - applies regardless of stall.
- Overflow is impossible by construction; underflow is prevented by the valid gating.

Optional Feature:
- Macro IQ_PERF_CNT_EN.
- Defined:
  - perf_empty_cyc increments each cycle count==0;
  - perf_dual_cnt increments when 2 entries pop;
  - perf_single_cnt increments when 1 entry pops.
  - All three saturate at all-ones, are cleared only by rstn, and are unaffected by flush.
- Undefined: all perf outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package iq_pkg holds:
  - field offset/width localparams for the packed entry (PC_LSB, NPC_LSB, IR_LSB, IMM_LSB, CTRL_LSB, RK_LSB, RJ_LSB, RD_LSB, EXCP_LSB, PRE_LSB);
  - ENTRY_W default;
  - the issue-type encoding constants shared with the dispatcher (0 alu … 11 mmu).
- Sub-module iq_storage: DEPTH×ENTRY_W register array with 2 write ports and 2 asynchronous read ports, no reset on data.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset, then push pc 0x1c000000/0x1c000004 → next cycle out_valid_old=1, out_valid_young=1, out_entry_old pc=0x1c000000, out_entry_young pc=0x1c000004.
- 4 entries queued, issue_old=1, issue_young=0 → head advances 1; the new old slot is the former young (pc 0x1c000004). Then issue both → head advances 2 and perf_dual_cnt=1 (with IQ_PERF_CNT_EN).
- Push pairs until count=7 with DEPTH=8 → in_ready=0. Pop 2 with push asserted → push ignored; in_ready=1 the cycle after count=5.
- Pointer wrap: 20 push/pop pairs with DEPTH=8 → output pc sequence stays strictly in order across index 7→0.
- stall=1 with issue flags 1 and a push of 2 → no pop, count+=2. Then flush=1 with push and pop active → next cycle count=0, out_valid_old=0, out_entry_old=0.
- in_valid1 only, pc 0x1c000100, into an empty queue → lands at old slot; out_valid_young=0; issue_young=1 with issue_old=0 → no pop.
